grf: RTL and testbench

- 32 x 32-bit MIPS general register file (GRF) for the pipelined CPU's decode stage.
- Two combinational read ports and one synchronous write port.
- Register $0 is hard-wired to zero.
- Synchronous active-low reset clears every register.

---
 rtl/grf_pkg.sv | 19 +
 rtl/grf_read_port.sv | 33 +++
 rtl/grf.sv | 92 +++++++++
 tb/tb_grf.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_pkg
// Description : Shared widths, register-index type and constants for the GRF.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    word_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage
`default_nettype wire

// File: rtl/grf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : grf_read_port
// Description : One combinational GRF read mux with $0 masking and an
//               optional write-to-read forwarding path.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_read_port
    import grf_pkg::*;
#(
    parameter int DATA_W   = grf_pkg::DATA_W,
    parameter int NUM_REGS = grf_pkg::NUM_REGS
) (
    input  logic [DATA_W-1:0] i_regs [NUM_REGS],
    input  reg_idx_t          i_addr,
    input  logic              i_byp_en,
    input  reg_idx_t          i_byp_addr,
    input  logic [DATA_W-1:0] i_byp_data,
    output logic [DATA_W-1:0] o_data
);

    // $0 masking takes precedence so a forwarded write can never surface there.
    always_comb begin
        o_data = i_regs[i_addr];
        if (i_addr == ZERO_REG) begin
            o_data = '0;
        end else if (i_byp_en && (i_addr == i_byp_addr)) begin
            o_data = i_byp_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/grf.sv
`default_nettype none
// ============================================================================
// Module      : grf
// Description : 32 x 32-bit MIPS general register file, two async read ports,
//               one sync write port, $0 hard-wired to zero.
//               Optional macro GRF_BYPASS_EN enables write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module grf
    import grf_pkg::*;
#(
    parameter int DATA_W   = grf_pkg::DATA_W,
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = grf_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              writable,
    input  logic [ADDR_W-1:0] read1addr,
    input  logic [ADDR_W-1:0] read2addr,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] read1data,
    output logic [DATA_W-1:0] read2data
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    reg_idx_t          w_waddr;
    reg_idx_t          w_raddr1;
    reg_idx_t          w_raddr2;
    logic              w_we;
    logic              w_byp_en;

    // Upper address bits alias onto the low five; only [4:0] select a register.
    assign w_waddr  = writeAddr[REG_IDX_W-1:0];
    assign w_raddr1 = read1addr[REG_IDX_W-1:0];
    assign w_raddr2 = read2addr[REG_IDX_W-1:0];

    generate
        if (ADDR_W > REG_IDX_W) begin : g_upper_bits
            logic w_unused_addr;
            assign w_unused_addr = ^{read1addr[ADDR_W-1:REG_IDX_W],
                                     read2addr[ADDR_W-1:REG_IDX_W],
                                     writeAddr[ADDR_W-1:REG_IDX_W]};
        end
    endgenerate

    assign w_we = writable && (w_waddr != ZERO_REG);

`ifdef GRF_BYPASS_EN
    assign w_byp_en = reset && w_we;
`else
    assign w_byp_en = 1'b0;
`endif

    // Reset wins over a simultaneous write; $0 is never a write target.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= writeData;
        end
    end

    grf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd1 (
        .i_regs     (r_regs),
        .i_addr     (w_raddr1),
        .i_byp_en   (w_byp_en),
        .i_byp_addr (w_waddr),
        .i_byp_data (writeData),
        .o_data     (read1data)
    );

    grf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd2 (
        .i_regs     (r_regs),
        .i_addr     (w_raddr2),
        .i_byp_en   (w_byp_en),
        .i_byp_addr (w_waddr),
        .i_byp_data (writeData),
        .o_data     (read2data)
    );

endmodule
`default_nettype wire

// File: tb/tb_grf.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf
// Description : Self-checking bench for grf: directed cases plus randomized
//               traffic against an array-based register file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf;
    import grf_pkg::*;

    logic        clk;
    logic        reset;
    logic        writable;
    logic [31:0] read1addr;
    logic [31:0] read2addr;
    logic [31:0] writeAddr;
    logic [31:0] writeData;
    logic [31:0] read1data;
    logic [31:0] read2data;

    word_t mem [32];
    int    n_cmp;
    int    n_bad;

    grf u_dut (
        .clk       (clk),
        .reset     (reset),
        .writable  (writable),
        .read1addr (read1addr),
        .read2addr (read2addr),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .read1data (read1data),
        .read2data (read2data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural view of a read given the current bench-driven inputs.
    function automatic word_t model_read(input logic [31:0] a);
        logic [4:0] idx;
        idx = a[4:0];
        if (idx == 5'd0) return 32'h0;
`ifdef GRF_BYPASS_EN
        if (reset && writable && writeAddr[4:0] != 5'd0 && writeAddr[4:0] == idx)
            return writeData;
`endif
        return mem[idx];
    endfunction

    function automatic void model_edge();
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (writable && writeAddr[4:0] != 5'd0) begin
            mem[writeAddr[4:0]] = writeData;
        end
    endfunction

    task automatic drive(input string tag, input logic rst_n, input logic we,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra1, input logic [31:0] ra2);
        @(negedge clk);
        reset     = rst_n;
        writable  = we;
        writeAddr = wa;
        writeData = wd;
        read1addr = ra1;
        read2addr = ra2;
        #1;
        check({tag, "_pre1"}, read1data, model_read(ra1));
        check({tag, "_pre2"}, read2data, model_read(ra2));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_post1"}, read1data, model_read(ra1));
        check({tag, "_post2"}, read2data, model_read(ra2));
    endtask

    task automatic peek(input string tag, input logic [31:0] ra1, input logic [31:0] ra2,
                        input logic [31:0] exp1, input logic [31:0] exp2);
        reset     = 1'b1;
        writable  = 1'b0;
        read1addr = ra1;
        read2addr = ra2;
        #1;
        check({tag, "_p1"}, read1data, exp1);
        check({tag, "_p2"}, read2data, exp2);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        reset     = 1'b0;
        writable  = 1'b0;
        writeAddr = 32'h0;
        writeData = 32'h0;
        read1addr = 32'h0;
        read2addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 32; i++) peek("reset_init", i, 31 - i, 32'h0, 32'h0);

        // Reset clears a previously written register.
        drive("wr5", 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd5, 32'd5);
        peek("wr5_chk", 32'd5, 32'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        drive("rst_a", 1'b0, 1'b0, 32'd0, 32'h0, 32'd5, 32'd1);
        drive("rst_b", 1'b0, 1'b0, 32'd0, 32'h0, 32'd5, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 32; i++) peek("reset_all", i, i ^ 31, 32'h0, 32'h0);

        // Reset beats a simultaneous write.
        drive("rst_prio", 1'b0, 1'b1, 32'd4, 32'd7, 32'd4, 32'd4);
        @(negedge clk);
        peek("rst_prio_chk", 32'd4, 32'd4, 32'h0, 32'h0);

        // Disabled write leaves $9 at its reset value.
        drive("wdis", 1'b1, 1'b0, 32'd9, 32'hA5A5_A5A5, 32'd9, 32'd9);
        @(negedge clk);
        peek("wdis_chk", 32'd9, 32'd9, 32'h0, 32'h0);

        drive("basic", 1'b1, 1'b1, 32'd8, 32'h1234_5678, 32'd8, 32'd8);
        @(negedge clk);
        peek("basic_chk", 32'd8, 32'd8, 32'h1234_5678, 32'h1234_5678);

        drive("zero_w", 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
        drive("zero_alias", 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 32'd0, 32'h20);
        @(negedge clk);
        peek("zero_chk", 32'd0, 32'h20, 32'h0, 32'h0);

        drive("alias23", 1'b1, 1'b1, 32'h23, 32'hCAFE_0003, 32'd3, 32'hFFFF_FFE3);
        @(negedge clk);
        peek("alias_chk", 32'd3, 32'h43, 32'hCAFE_0003, 32'hCAFE_0003);

        // Same-cycle write/read hazard on $3.
        drive("haz_init", 1'b1, 1'b1, 32'd3, 32'd1, 32'd3, 32'd0);
        @(negedge clk);
        writable  = 1'b1;
        writeAddr = 32'd3;
        writeData = 32'd2;
        read1addr = 32'd3;
        read2addr = 32'd0;
        #1;
`ifdef GRF_BYPASS_EN
        check("hazard_pre", read1data, 32'd2);
`else
        check("hazard_pre", read1data, 32'd1);
`endif
        check("hazard_zero", read2data, 32'd0);
        @(posedge clk);
        mem[3] = 32'd2;
        #1;
        check("hazard_post", read1data, 32'd2);

        // Full sweep: $i = i*3.
        for (int i = 1; i < 32; i++) drive("sweep_wr", 1'b1, 1'b1, i, i * 3, i, 32 - i);
        @(negedge clk);
        for (int i = 0; i < 32; i++) peek("sweep_rd", i, i, i * 3, i * 3);

        // Randomized traffic with occasional resets and random upper address bits.
        for (int n = 0; n < 400; n++) begin
            drive("rand", ($urandom_range(0, 24) != 0), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
